// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: default widths,
// opcode encodings, default format/legality masks and the decoded-fields
// record held by the main and skid registers.
package decode_pkg;

  localparam int INST_W_DEF = 32;
  localparam int OPC_W_DEF  = 3;
  localparam int REG_W_DEF  = 5;
  localparam int ADDR_W_DEF = INST_W_DEF - OPC_W_DEF - 2 * REG_W_DEF;

  // Opcode encodings: 0..3 register-register, 4..6 memory/address, 7 reserved
  localparam logic [OPC_W_DEF-1:0] OPC_ADD    = 3'd0;
  localparam logic [OPC_W_DEF-1:0] OPC_SUB    = 3'd1;
  localparam logic [OPC_W_DEF-1:0] OPC_AND    = 3'd2;
  localparam logic [OPC_W_DEF-1:0] OPC_OR     = 3'd3;
  localparam logic [OPC_W_DEF-1:0] OPC_LOAD   = 3'd4;
  localparam logic [OPC_W_DEF-1:0] OPC_STORE  = 3'd5;
  localparam logic [OPC_W_DEF-1:0] OPC_BRANCH = 3'd6;
  localparam logic [OPC_W_DEF-1:0] OPC_RSVD   = 3'd7;

  // Bit n set means opcode n uses the R-type layout
  localparam logic [7:0] FMT_R_MASK_DEF = (8'd1 << OPC_ADD) | (8'd1 << OPC_SUB) |
                                          (8'd1 << OPC_AND) | (8'd1 << OPC_OR);
  // Bit n set means opcode n is legal; only the reserved opcode is rejected
  localparam logic [7:0] LEGAL_MASK_DEF = ~(8'd1 << OPC_RSVD);

  // Decoded instruction as carried through the main and skid registers
  typedef struct packed {
    logic [OPC_W_DEF-1:0]  opcode;
    logic [REG_W_DEF-1:0]  reg_addr_0;
    logic [REG_W_DEF-1:0]  reg_addr_1;
    logic [REG_W_DEF-1:0]  reg_addr_2;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  is_rtype;
    logic                  illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_stage_field_extract.sv
// Purely combinational field slicer: splits an instruction word into its
// fields, applies R/M format masking to resolve the reg_addr_2/addr overlap,
// and flags opcodes that are not legal.
module field_extract
  import decode_pkg::*;
#(
  parameter int                    INST_W     = INST_W_DEF,
  parameter int                    OPC_W      = OPC_W_DEF,
  parameter int                    REG_W      = REG_W_DEF,
  parameter logic [2**OPC_W-1:0]   FMT_R_MASK = FMT_R_MASK_DEF,
  parameter logic [2**OPC_W-1:0]   LEGAL_MASK = LEGAL_MASK_DEF
) (
  input  logic [INST_W-1:0] inst,
  output dec_fields_t       fields
);

  localparam int ADDR_W = INST_W - OPC_W - 2 * REG_W;

  logic [OPC_W-1:0] opc_s;
  logic             is_r_s;

  assign opc_s  = inst[INST_W-1 -: OPC_W];
  assign is_r_s = FMT_R_MASK[opc_s];

  // Slice fields; format selects which of the two overlapping fields survives
  always_comb begin
    fields            = '0;
    fields.opcode     = opc_s;
    fields.reg_addr_0 = inst[INST_W-OPC_W-1 -: REG_W];
    fields.reg_addr_1 = inst[INST_W-OPC_W-REG_W-1 -: REG_W];
    fields.is_rtype   = is_r_s;
    fields.illegal    = ~LEGAL_MASK[opc_s];
    if (is_r_s) begin
      fields.reg_addr_2 = inst[ADDR_W-1 -: REG_W];
      fields.addr       = '0;
    end else begin
      fields.reg_addr_2 = '0;
      fields.addr       = inst[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready on both sides and a
// two-entry (main + skid) buffer so in_ready comes straight from a flop.
// Optional feature macro: DECODE_STATS_EN adds inst_count (wrapping output
// transfer count) and illegal_count (saturating accepted-illegal count).
module decode_stage
  import decode_pkg::*;
#(
  parameter int                    INST_W     = INST_W_DEF,
  parameter int                    OPC_W      = OPC_W_DEF,
  parameter int                    REG_W      = REG_W_DEF,
  parameter logic [2**OPC_W-1:0]   FMT_R_MASK = FMT_R_MASK_DEF,
  parameter logic [2**OPC_W-1:0]   LEGAL_MASK = LEGAL_MASK_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INST_W-1:0]                    inst,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OPC_W-1:0]                     opcode,
  output logic [REG_W-1:0]                     reg_addr_0,
  output logic [REG_W-1:0]                     reg_addr_1,
  output logic [REG_W-1:0]                     reg_addr_2,
  output logic [INST_W-OPC_W-2*REG_W-1:0]      addr,
  output logic                                 is_rtype,
  output logic                                 illegal,
`ifdef DECODE_STATS_EN
  output logic [31:0]                          inst_count,
  output logic [15:0]                          illegal_count,
`endif
  output logic                                 err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t      state_r;
  dec_fields_t main_r;
  dec_fields_t skid_r;
  dec_fields_t fields_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        err_r;
  logic        in_xfer_s;
  logic        out_xfer_s;

  field_extract #(
    .INST_W     (INST_W),
    .OPC_W      (OPC_W),
    .REG_W      (REG_W),
    .FMT_R_MASK (FMT_R_MASK),
    .LEGAL_MASK (LEGAL_MASK)
  ) u_field_extract (
    .inst   (inst),
    .fields (fields_s)
  );

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Buffer state machine: main register drives outputs, skid absorbs one stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_r      <= fields_s;
            state_r     <= ST_FULL;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer_s && out_xfer_s) begin
            main_r <= fields_s;
          end else if (in_xfer_s) begin
            skid_r     <= fields_s;
            state_r    <= ST_SKID;
            in_ready_r <= 1'b0;
          end else if (out_xfer_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_SKID: begin
          if (out_xfer_s) begin
            main_r     <= skid_r;
            state_r    <= ST_FULL;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: any accepted illegal instruction, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (in_xfer_s && fields_s.illegal) begin
      err_r <= 1'b1;
    end
  end

`ifdef DECODE_STATS_EN
  logic [31:0] inst_count_r;
  logic [15:0] illegal_count_r;

  // Output transfer counter, wraps naturally at 2**32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count_r <= 32'd0;
    end else if (out_xfer_s) begin
      inst_count_r <= inst_count_r + 32'd1;
    end
  end

  // Accepted-illegal counter, holds at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_count_r <= 16'd0;
    end else if (in_xfer_s && fields_s.illegal && (illegal_count_r != 16'hFFFF)) begin
      illegal_count_r <= illegal_count_r + 16'd1;
    end
  end

  assign inst_count    = inst_count_r;
  assign illegal_count = illegal_count_r;
`endif

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign opcode     = main_r.opcode;
  assign reg_addr_0 = main_r.reg_addr_0;
  assign reg_addr_1 = main_r.reg_addr_1;
  assign reg_addr_2 = main_r.reg_addr_2;
  assign addr       = main_r.addr;
  assign is_rtype   = main_r.is_rtype;
  assign illegal    = main_r.illegal;
  assign err        = err_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  opcode;
  logic [4:0]  reg_addr_0, reg_addr_1, reg_addr_2;
  logic [18:0] addr;
  logic        is_rtype, illegal, err;
`ifdef DECODE_STATS_EN
  logic [31:0] inst_count;
  logic [15:0] illegal_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Hand-computed instruction words and their expected decode
  // {out_valid, opcode, ra0, ra1, ra2, addr, is_rtype, illegal}
  localparam logic [31:0] I_A = 32'h2219_0000;
  localparam logic [31:0] I_B = 32'hA100_1234;
  localparam logic [31:0] I_C = 32'h4531_C000;
  localparam logic [31:0] I_D = 32'h8957_ABCD;
  localparam logic [31:0] I_X = 32'hE000_0000;
  localparam logic [40:0] E_A = {1'b1, 3'd1, 5'd2, 5'd3, 5'd4, 19'h00000, 1'b1, 1'b0};
  localparam logic [40:0] E_B = {1'b1, 3'd5, 5'd1, 5'd0, 5'd0, 19'h01234, 1'b0, 1'b0};
  localparam logic [40:0] E_C = {1'b1, 3'd2, 5'd5, 5'd6, 5'd7, 19'h00000, 1'b1, 1'b0};
  localparam logic [40:0] E_D = {1'b1, 3'd4, 5'd9, 5'd10, 5'd0, 19'h7ABCD, 1'b0, 1'b0};
  localparam logic [40:0] E_X = {1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 19'h00000, 1'b0, 1'b1};

  logic [40:0] obs;
  assign obs = {out_valid, opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr, is_rtype, illegal};

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inst       (inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .opcode     (opcode),
    .reg_addr_0 (reg_addr_0),
    .reg_addr_1 (reg_addr_1),
    .reg_addr_2 (reg_addr_2),
    .addr       (addr),
    .is_rtype   (is_rtype),
    .illegal    (illegal),
`ifdef DECODE_STATS_EN
    .inst_count    (inst_count),
    .illegal_count (illegal_count),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    inst = I_A;
    step();
    step();
    total_cnt++;
    if ({in_ready, obs, err} !== {1'b1, 41'd0, 1'b0}) begin
      $display("FAIL reset_state: got %h want %h", {in_ready, obs, err}, {1'b1, 41'd0, 1'b0});
    end else pass_cnt++;
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL reset_release: got %b want 10", {in_ready, out_valid});
    end else pass_cnt++;
  endtask

  task automatic test_rtype();
    out_ready = 1'b1;
    in_valid = 1'b1;
    inst = I_A;
    step();
    in_valid = 1'b0;
    inst = 32'hFFFF_FFFF;
    total_cnt++;
    if (obs !== E_A) $display("FAIL rtype_decode: got %h want %h", obs, E_A);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rtype_drain: out_valid got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_mtype();
    out_ready = 1'b1;
    in_valid = 1'b1;
    inst = I_B;
    step();
    total_cnt++;
    if (obs !== E_B) $display("FAIL mtype_decode: got %h want %h", obs, E_B);
    else pass_cnt++;
    inst = I_D;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (obs !== E_D) $display("FAIL mtype_overlap_mask: got %h want %h", obs, E_D);
    else pass_cnt++;
    step();
  endtask

  task automatic test_illegal();
    int bad;
    out_ready = 1'b1;
    total_cnt++;
    if (err !== 1'b0) $display("FAIL illegal_pre_err: got %b want 0", err);
    else pass_cnt++;
    in_valid = 1'b1;
    inst = I_X;
    step();
    total_cnt++;
    if ({obs, err} !== {E_X, 1'b1}) $display("FAIL illegal_decode: got %h want %h", {obs, err}, {E_X, 1'b1});
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      inst = (i % 2 == 0) ? I_A : I_B;
      step();
      if (err !== 1'b1 || illegal !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (bad != 0 || err !== 1'b1) $display("FAIL illegal_sticky: bad cycles %0d err %b want 0 and 1", bad, err);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (err !== 1'b0) $display("FAIL illegal_clear: err got %b want 0", err);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = I_A;
    step();
    total_cnt++;
    if ({in_ready, obs} !== {1'b1, E_A}) $display("FAIL bp_first: got %h want %h", {in_ready, obs}, {1'b1, E_A});
    else pass_cnt++;
    inst = I_B;
    step();
    total_cnt++;
    if ({in_ready, obs} !== {1'b0, E_A}) $display("FAIL bp_skid: got %h want %h", {in_ready, obs}, {1'b0, E_A});
    else pass_cnt++;
    inst = I_C;
    step();
    step();
    total_cnt++;
    if ({in_ready, obs} !== {1'b0, E_A}) $display("FAIL bp_stable: got %h want %h", {in_ready, obs}, {1'b0, E_A});
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({in_ready, obs} !== {1'b1, E_B}) $display("FAIL bp_second: got %h want %h", {in_ready, obs}, {1'b1, E_B});
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== E_C) $display("FAIL bp_third: got %h want %h", obs, E_C);
    else pass_cnt++;
    inst = I_D;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (obs !== E_D) $display("FAIL bp_fourth: got %h want %h", obs, E_D);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = I_X;
    step();
    inst = I_B;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready, err} !== 3'b101) $display("FAIL mid_pre: got %b want 101", {out_valid, in_ready, err});
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, err} !== 3'b010) $display("FAIL mid_async: got %b want 010", {out_valid, in_ready, err});
    else pass_cnt++;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    inst = I_C;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (obs !== E_C) $display("FAIL mid_first_new: got %h want %h", obs, E_C);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_no_stale: out_valid got %b want 0", out_valid);
    else pass_cnt++;
  endtask

`ifdef DECODE_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      inst = (i == 10 || i == 50 || i == 90) ? I_X : I_C;
      step();
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (inst_count !== 32'd100) $display("FAIL stats_inst: got %0d want 100", inst_count);
    else pass_cnt++;
    total_cnt++;
    if (illegal_count !== 16'd3) $display("FAIL stats_illegal: got %0d want 3", illegal_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_mtype();
    test_illegal();
    test_backpressure();
    test_reset_mid();
`ifdef DECODE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction decode stage between the fetch unit and the register file / execute stage.
- Splits each instruction word into opcode, three register addresses and an address/immediate field.
- Selects R-type or M-type field formats per opcode and flags illegal opcodes.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
- INST_W, 32: instruction word width.
- OPC_W, 3: opcode width, taken from the MSBs.
- REG_W, 5: width of each register address.
- ADDR_W, INST_W-OPC_W-2*REG_W (19): width of the address/immediate field, taken from the LSBs. Derived; not overridden.
- FMT_R_MASK, 8'b0000_1111: bit n=1 means opcode n is R-type. Width 2**OPC_W.
- LEGAL_MASK, 8'b0111_1111: bit n=1 means opcode n is legal. Width 2**OPC_W.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: instruction valid.
- in_ready, output, 1: stage can accept.
- inst, input, INST_W: instruction word.
- out_valid, output, 1: decoded fields valid.
- out_ready, input, 1: downstream accepts.
- opcode, output, OPC_W: opcode field.
- reg_addr_0, output, REG_W: destination register.
- reg_addr_1, output, REG_W: source register 1.
- reg_addr_2, output, REG_W: source register 2. R-type only; 0 otherwise.
- addr, output, ADDR_W: address field. M-type only; 0 otherwise.
- is_rtype, output, 1: decoded instruction is R-type.
- illegal, output, 1: opcode not set in LEGAL_MASK.
- err, output, 1: sticky flag; an illegal instruction has been accepted.

Behaviour:
- Field layout:
  - opcode = inst[INST_W-1 -: OPC_W]
  - reg_addr_0 = next REG_W bits below opcode
  - reg_addr_1 = next REG_W bits
  - reg_addr_2 = next REG_W bits
  - addr = inst[ADDR_W-1:0]
  - reg_addr_2 overlaps the top of addr. Format masking resolves the overlap.
- R-type (FMT_R_MASK[opcode]=1): addr output forced to 0, is_rtype=1.
- M-type: reg_addr_2 output forced to 0, is_rtype=0.
- Illegal opcode: fields are still decoded normally, illegal=1. On acceptance (in_valid & in_ready), err is set and is cleared only by rst.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Outputs are held stable while out_valid & !out_ready.
  - Latency: 1 cycle from input transfer to out_valid.
  - Throughput: 1 instruction per cycle.
- State machine (main register + skid register):
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> FULL.
  - FULL: in_ready=1, out_valid=1.
    - In & out transfer together -> main loads the new instruction, stay FULL.
    - In transfer only -> skid captures it -> SKID.
    - Out transfer only -> EMPTY.
  - SKID: in_ready=0, out_valid=1. Out transfer -> main <= skid -> FULL.
- Ordering is strictly in-order. No instruction is dropped or duplicated.
- Reset, async, while rst is high:
  - State EMPTY, out_valid=0, in_ready=1.
  - All field outputs, is_rtype, illegal and err are 0.
  - in_valid is ignored.
  - Reset mid-operation discards both buffered entries.
- Decoded fields are registered. No combinational path exists from inst to the outputs, or from out_ready to in_ready.

Optional Feature:
- Macro: DECODE_STATS_EN.
- Defined: adds output inst_count[31:0], which counts output transfers and wraps at 2**32.
- Defined: adds output illegal_count[15:0], which counts accepted illegal instructions and saturates at 16'hFFFF.
- Both counters reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package decode_pkg holds:
  - default widths
  - opcode localparams
  - default FMT_R_MASK / LEGAL_MASK
  - a packed decoded-fields struct typedef used by the main and skid registers
- Sub-module field_extract: pure combinational slice, format masking and illegal check, producing the struct. decode_stage holds the state machine, registers and counters.

Test Plan:
- R-type: inst=32'h2219_0000, out_ready=1 -> next cycle out_valid=1, opcode=1, reg_addr_0=2, reg_addr_1=3, reg_addr_2=4, addr=0, is_rtype=1, illegal=0.
- M-type: inst=32'hA100_1234 -> opcode=5, reg_addr_0=1, reg_addr_1=0, reg_addr_2=0, addr=19'h01234, is_rtype=0.
- Illegal: inst=32'hE000_0000 accepted -> illegal=1, err=1. err stays 1 through 10 further legal instructions and clears only on rst.
- Backpressure: stream 4 distinct instructions with out_ready=0:
  - first two accepted, in_ready=0 from cycle 2
  - release out_ready -> all 4 emerge in order, no loss or duplication, outputs stable while stalled.
- Reset mid-stream: assert rst asynchronously while in SKID -> out_valid=0, in_ready=1, err=0 immediately. After release, the first new instruction is the first one out.
- DECODE_STATS_EN: 100 back-to-back transfers including 3 illegal -> inst_count=100, illegal_count=3. Without the macro, the bench compiles with no stats ports.
